// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizes for the memory arbiter and the memory it fronts.
// The defaults here must match the memory's top-level instantiation.
package mem_arb_pkg;

  localparam int DEF_WIDTH   = 2;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester command ports plus the single memory command/response port of the arbiter.
// slave = arbiter view, master = requesters and memory seen from the outside.
interface mem_arbiter_if #(
  parameter int WIDTH      = mem_arb_pkg::DEF_WIDTH,
  parameter int DEPTH      = mem_arb_pkg::DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_REQ    = mem_arb_pkg::DEF_NUM_REQ
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_wr_rd;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]      req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [WIDTH-1:0]              req_rdata;
  logic                          busy;
  logic                          mem_valid;
  logic                          mem_wr_rd;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [WIDTH-1:0]              mem_wdata;
  logic                          mem_ready;
  logic [WIDTH-1:0]              mem_rdata;

  modport slave (
    input  req_valid, req_wr_rd, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, req_rdata, busy, mem_valid, mem_wr_rd, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr_rd, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, req_rdata, busy, mem_valid, mem_wr_rd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin search starting at ptr_i; zero latency, no state.
// Returns a one-hot grant, its binary index and whether anything was requesting.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr_i never exceeds NUM_REQ-1, so one subtraction wraps the search
      j = int'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin front end for one single-port memory: 3 cycles request-to-ready, 4 per op back-to-back.
// Losers simply hold valid; WAIT lasts as long as the memory withholds ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic          clk,
  input  logic          res,
  mem_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                state_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      ptr_d;
  logic [IDX_W-1:0]      win_idx_q;
  logic [NUM_REQ-1:0]    win_oh_q;
  logic                  mem_valid_q;
  logic                  mem_wr_rd_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0]      mem_wdata_q;
  logic [NUM_REQ-1:0]    req_ready_q;
  logic [WIDTH-1:0]      req_rdata_q;
  logic                  busy_q;

  logic [NUM_REQ-1:0]    gnt_oh;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Priority moves to the requester just after the one being served
  always_comb begin
    ptr_d = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_idx_q   <= '0;
      win_oh_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_ready_q <= '0;
      req_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            state_q     <= ISSUE;
            win_idx_q   <= gnt_idx;
            win_oh_q    <= gnt_oh;
            mem_wr_rd_q <= bus.req_wr_rd[gnt_idx];
            mem_addr_q  <= bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_q <= bus.req_wdata[int'(gnt_idx)*WIDTH +: WIDTH];
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          state_q     <= WAIT;
          mem_valid_q <= 1'b0;
        end
        WAIT: begin
          if (bus.mem_ready) begin
            state_q     <= RESP;
            req_ready_q <= win_oh_q;
            // Writes leave the last read value visible to requesters
            if (!mem_wr_rd_q) req_rdata_q <= bus.mem_rdata;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= '0;
          busy_q      <= 1'b0;
          ptr_q       <= ptr_d;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_wr_rd = mem_wr_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.req_ready = req_ready_q;
  assign bus.req_rdata = req_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and a queue-based scoreboard.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic res = 1'b0;

  initial forever #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(2), .DEPTH(4), .NUM_REQ(2)) bus ();

  mem_arbiter #(.WIDTH(2), .DEPTH(4), .NUM_REQ(2)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  logic [1:0] tv     = '0;
  logic [1:0] twr    = '0;
  logic [3:0] taddr  = '0;
  logic [3:0] twd    = '0;
  logic       mready = 1'b0;
  logic [1:0] mrdata = '0;

  assign bus.req_valid = tv;
  assign bus.req_wr_rd = twr;
  assign bus.req_addr  = taddr;
  assign bus.req_wdata = twd;
  assign bus.mem_ready = mready;
  assign bus.mem_rdata = mrdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nvalid = 0;
  int nready = 0;
  int extra_wait = 0;
  int last_rdy = 0;
  bit int_en = 1'b0;
  bit have_last = 1'b0;

  typedef struct {
    int         idx;
    logic [1:0] rd;
  } exp_t;
  exp_t expq[$];

  logic [1:0] mem [4];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [1:0] rd);
    exp_t e;
    e.idx = idx;
    e.rd  = rd;
    expq.push_back(e);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 4; k++) mem[k] = 2'b00;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_req_rdata"}, 32'(bus.req_rdata), 0);
    chk({tag, "_mem_valid"}, 32'(bus.mem_valid), 0);
    chk({tag, "_mem_cmd"}, 32'({bus.mem_wr_rd, bus.mem_addr, bus.mem_wdata}), 0);
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic do_req(input int i, input bit wr, input logic [1:0] a,
                        input logic [1:0] d, input int lat);
    int t0;
    bit seen;
    tv[i] = 1'b1;
    twr[i] = wr;
    taddr[i*2 +: 2] = a;
    twd[i*2 +: 2] = d;
    t0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) seen = 1'b1;
    end
    if (!seen) chk($sformatf("ready_timeout_req%0d", i), 32'(seen), 1);
    else if (lat != 0) chk($sformatf("latency_req%0d", i), 32'(cyc - t0), 32'(lat));
    @(posedge clk);
    #1;
    tv[i] = 1'b0;
  endtask

  // Memory: ready one cycle after a sampled valid, plus extra_wait cycles
  initial begin
    logic [1:0] a;
    logic [1:0] d;
    bit         w;
    forever begin
      @(negedge clk);
      if (res && bus.mem_valid) begin
        a = bus.mem_addr;
        w = bus.mem_wr_rd;
        d = bus.mem_wdata;
        repeat (extra_wait) @(posedge clk);
        @(posedge clk);
        #1;
        if (res) begin
          if (w) begin
            mem[a] = d;
            mrdata = d ^ 2'b01;
          end else begin
            mrdata = mem[a];
          end
          mready = 1'b1;
          @(posedge clk);
          #1;
          mready = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res) begin
        if (bus.mem_valid) nvalid++;
        if (bus.req_ready != 2'b00) begin
          nready++;
          if (expq.size() == 0) begin
            chk("unexpected_ready", 32'(bus.req_ready), 0);
          end else begin
            e = expq.pop_front();
            chk("grant", 32'(bus.req_ready), 32'(1 << e.idx));
            chk("rdata", 32'(bus.req_rdata), 32'(e.rd));
          end
          if (int_en) begin
            if (have_last) chk("ready_interval", 32'(cyc - last_rdy), 4);
            have_last = 1'b1;
            last_rdy = cyc;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    bit s;
    clear_mem();
    res = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset");
    res = 1'b1;
    @(posedge clk);
    #1;

    // Single write then read
    push(0, 2'b00); do_req(0, 1'b1, 2'd2, 2'b10, 3);
    push(0, 2'b10); do_req(0, 1'b0, 2'd2, 2'b00, 3);

    // Read data holds across a write
    push(0, 2'b00); do_req(0, 1'b0, 2'd0, 2'b00, 3);
    push(0, 2'b00); do_req(0, 1'b1, 2'd0, 2'b11, 3);
    push(0, 2'b11); do_req(0, 1'b0, 2'd0, 2'b00, 3);

    // Reset while the transfer sits in WAIT
    extra_wait = 3;
    tv[1] = 1'b1;
    twr[1] = 1'b0;
    taddr[3:2] = 2'd2;
    s = 1'b0;
    for (int k = 0; k < 20 && !s; k++) begin
      @(negedge clk);
      if (bus.mem_valid) s = 1'b1;
    end
    chk("midwait_issue_seen", 32'(s), 1);
    repeat (2) @(posedge clk);
    #2;
    res = 1'b0;
    clear_mem();
    #1;
    chk_rst("midwait");
    tv[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    extra_wait = 0;
    res = 1'b1;
    nvalid = 0;
    nready = 0;

    // Contention straight after reset: requester 0 has priority
    push(0, 2'b00);
    push(1, 2'b00);
    fork
      do_req(0, 1'b1, 2'd1, 2'd1, 3);
      do_req(1, 1'b1, 2'd3, 2'd3, 0);
    join
    push(1, 2'd1); do_req(1, 1'b0, 2'd1, 2'd0, 3);
    push(0, 2'd3); do_req(0, 1'b0, 2'd3, 2'd0, 3);

    // Fairness: both hold valid continuously for six operations
    res = 1'b0;
    clear_mem();
    @(posedge clk);
    #1;
    res = 1'b1;
    nvalid = 0;
    nready = 0;
    have_last = 1'b0;
    int_en = 1'b1;
    push(0, 2'd0); push(1, 2'd0); push(0, 2'd3);
    push(1, 2'd1); push(0, 2'd1); push(1, 2'd2);
    fork
      begin
        do_req(0, 1'b1, 2'd0, 2'd1, 0);
        do_req(0, 1'b0, 2'd1, 2'd0, 0);
        do_req(0, 1'b1, 2'd2, 2'd2, 0);
      end
      begin
        do_req(1, 1'b1, 2'd1, 2'd3, 0);
        do_req(1, 1'b0, 2'd0, 2'd0, 0);
        do_req(1, 1'b0, 2'd2, 2'd0, 0);
      end
    join
    int_en = 1'b0;

    // Slow memory stretches WAIT; valid held through RESP
    extra_wait = 2;
    push(1, 2'd3); do_req(1, 1'b0, 2'd1, 2'd0, 5);
    extra_wait = 0;

    repeat (6) @(posedge clk);
    #1;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("pulse_balance", 32'(nvalid), 32'(nready));
    chk("ready_count", 32'(nready), 7);
    chk("queue_empty", 32'(expq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
